// File: rtl/acc_pkg.sv
// Shared types and helpers for the multi-channel saturating accumulator.
// acc_op_t is the per-request opcode; sext sign-extends a w-bit field to SEXT_W bits.
package acc_pkg;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    LOAD  = 2'd1,
    CLEAR = 2'd2,
    READ  = 2'd3
  } acc_op_t;

  localparam int SEXT_W = 64;

  // Sign-extend the low w bits of x; callers size the result with a cast.
  function automatic logic signed [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] x,
                                                    input int unsigned      w);
    logic signed [SEXT_W-1:0] t;
    t = x << (SEXT_W - w);
    return t >>> (SEXT_W - w);
  endfunction

endpackage

// File: rtl/sat_clamp.sv
// Symmetric clamp of an ACC_W+1 bit signed value to [-lim, +lim].
// Since lim < 2^(ACC_W-1), the most negative ACC_W code can never come out.
module sat_clamp #(
  parameter int ACC_W = 40
) (
  input  logic signed [ACC_W:0]   i_v,
  input  logic        [ACC_W-2:0] i_lim,
  output logic signed [ACC_W-1:0] o_res,
  output logic                    o_sat
);

  logic signed [ACC_W:0] w_pos;
  logic signed [ACC_W:0] w_neg;

  assign w_pos = $signed({2'b00, i_lim});
  assign w_neg = -w_pos;

  // NOTE: every output gets a default before the branches, so no latch is inferred.
  always_comb begin
    o_res = i_v[ACC_W-1:0];
    o_sat = 1'b0;
    if (i_v > w_pos) begin
      o_res = w_pos[ACC_W-1:0];
      o_sat = 1'b1;
    end else if (i_v < w_neg) begin
      o_res = w_neg[ACC_W-1:0];
      o_sat = 1'b1;
    end
  end

endmodule

// File: rtl/acc_multi_sat.sv
// Multi-channel signed accumulator with symmetric clamping and sticky saturation flags.
// S1 captures the request plus its bypassed operand; S2 computes, writes back and registers outputs.
module acc_multi_sat
  import acc_pkg::*;
#(
  parameter  int IN_W     = 32,
  parameter  int ACC_W    = 40,
  parameter  int CHANNELS = 4,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic [CH_W-1:0]         in_ch,
  input  acc_op_t                 in_op,
  input  logic [IN_W-1:0]         in_data,
  input  logic [ACC_W-2:0]        lim,
  output logic                    out_valid,
  output logic [CH_W-1:0]         out_ch,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_sat,
  output logic [CHANNELS-1:0]     sat_sticky
);

  logic signed [ACC_W-1:0] r_acc [CHANNELS];

  logic                    r_s1_valid;
  logic [CH_W-1:0]         r_s1_ch;
  acc_op_t                 r_s1_op;
  logic [IN_W-1:0]         r_s1_data;
  logic [ACC_W-1:0]        r_s1_operand;

  logic                    r_out_valid;
  logic [CH_W-1:0]         r_out_ch;
  logic signed [ACC_W-1:0] r_out_data;
  logic                    r_out_sat;
  logic [CHANNELS-1:0]     r_sticky;

  logic signed [ACC_W:0]   w_data_ext;
  logic signed [ACC_W:0]   w_op_ext;
  logic signed [ACC_W:0]   w_v;
  logic signed [ACC_W-1:0] w_clamped;
  logic                    w_clamp_sat;
  logic                    w_sat;
  logic                    w_wr_en;
  logic signed [ACC_W-1:0] w_wr_val;
  logic                    w_in_ok;
  logic [ACC_W-1:0]        w_arr_rd;
  logic [ACC_W-1:0]        w_operand;

  // ---- S2 datapath (combinational from the S1 registers) ----
  assign w_data_ext = (ACC_W+1)'(sext(SEXT_W'(r_s1_data), IN_W));
  assign w_op_ext   = (ACC_W+1)'(sext(SEXT_W'(r_s1_operand), ACC_W));

  always_comb begin
    w_v = w_data_ext;
    if (r_s1_op == ACC) w_v = w_op_ext + w_data_ext;
  end

  sat_clamp #(.ACC_W(ACC_W)) u_clamp (
    .i_v   (w_v),
    .i_lim (lim),
    .o_res (w_clamped),
    .o_sat (w_clamp_sat)
  );

  assign w_wr_en  = r_s1_valid && (r_s1_op != READ);
  assign w_wr_val = (r_s1_op == CLEAR) ? '0 : w_clamped;
  assign w_sat    = w_clamp_sat && ((r_s1_op == ACC) || (r_s1_op == LOAD));

  // ---- S1 operand fetch with bypass of the write happening this same edge ----
  assign w_in_ok = in_valid && (int'(in_ch) < CHANNELS);

  always_comb begin
    w_arr_rd = '0;
    if (w_in_ok) w_arr_rd = r_acc[in_ch];
  end

  assign w_operand = (w_wr_en && (r_s1_ch == in_ch)) ? w_wr_val : w_arr_rd;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the channel array is reset explicitly, since a cleared accumulator is architectural state.
      for (int i = 0; i < CHANNELS; i++) r_acc[i] <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_ch      <= '0;
      r_s1_op      <= ACC;
      r_s1_data    <= '0;
      r_s1_operand <= '0;
      r_out_valid  <= 1'b0;
      r_out_ch     <= '0;
      r_out_data   <= '0;
      r_out_sat    <= 1'b0;
      r_sticky     <= '0;
    end else if (en) begin
      r_s1_valid   <= w_in_ok;
      r_s1_ch      <= in_ch;
      r_s1_op      <= in_op;
      r_s1_data    <= in_data;
      r_s1_operand <= w_operand;

      if (w_wr_en) r_acc[r_s1_ch] <= w_wr_val;

      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_ch   <= r_s1_ch;
        r_out_data <= (r_s1_op == READ) ? $signed(r_s1_operand) : w_wr_val;
        r_out_sat  <= w_sat;
        if (r_s1_op == CLEAR)  r_sticky[r_s1_ch] <= 1'b0;
        else if (w_sat)        r_sticky[r_s1_ch] <= 1'b1;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_ch     = r_out_ch;
  assign out_data   = r_out_data;
  assign out_sat    = r_out_sat;
  assign sat_sticky = r_sticky;

endmodule
